anim_sequencer: RTL
===================

ANIM_SEQUENCER -- requirements
Module: anim_sequencer

Interface
REQ-001 The block SHALL have parameter TEXT_Y0, default 20, meaning text top row in WAIT.
REQ-002 The block SHALL have parameter FALL_END_Y, default 276, meaning text top row at which the fall ends.
REQ-003 The block SHALL have parameter FALL_STEP, default 2, meaning rows added per advanced frame in FALL (range 1..15).
REQ-004 The block SHALL have parameter WAIT_FRAMES, default 128, meaning advanced frames spent in WAIT (range 1..256).
REQ-005 The block SHALL have parameter HIDE_FRAMES, default 32, meaning advanced frames spent in HIDE (range 1..256).
REQ-006 The block SHALL have port clk, input, 1 bit: pixel clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 The block SHALL have port vsync, input, 1 bit: active-low vertical sync from the timing generator.
REQ-009 The block SHALL have port pause, input, 1 bit: freeze animation while high (level).
REQ-010 The block SHALL have port step, input, 1 bit: single-frame advance request while paused (edge).
REQ-011 The block SHALL have port speed, input, 2 bits: texture phase increment exponent.
REQ-012 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse per frame.
REQ-013 The block SHALL have port frame_cnt, output, 16 bits: advanced-frame counter.
REQ-014 The block SHALL have port tex_phase, output, 8 bits: ring texture scroll phase for the renderer.
REQ-015 The block SHALL have port text_y, output, 10 bits: text top row for the renderer.
REQ-016 The block SHALL have port text_visible, output, 1 bit: renderer draws text only when high.
REQ-017 The block SHALL have port state, output, 2 bits: WAIT=0, FALL=1, HIDE=2.

Function
REQ-018 The block SHALL register vsync into vsync_prev every clock; a frame event occurs at the clock edge where vsync=0 and vsync_prev=1.
REQ-019 On each frame event the block SHALL register frame_tick=1 for exactly one cycle, regardless of pause; frame_tick SHALL be 0 otherwise.
REQ-020 A frame event SHALL be "advanced" when pause=0, or when pause=1 and a step request is pending.
REQ-021 The block SHALL detect a step rising edge (registered step_prev) while pause=1 and set step_pending; step edges while pause=0 SHALL be ignored.
REQ-022 The block SHALL clear step_pending on the advanced frame that consumes it; an edge coinciding with that frame event SHALL set step_pending for the next frame (set wins).
REQ-023 On an advanced frame the block SHALL increment frame_cnt by 1, wrapping 0xFFFF->0x0000.
REQ-024 On an advanced frame the block SHALL add (1 << speed) to tex_phase modulo 256, using the speed value sampled at that edge.
REQ-025 All outputs other than frame_tick SHALL update on the same edge that sets frame_tick, with no further latency.
REQ-026 In WAIT, each advanced frame SHALL increment an 8-bit dwell counter; when dwell equals WAIT_FRAMES-1, the block SHALL enter FALL and clear dwell.
REQ-027 In FALL, each advanced frame SHALL compute text_y+FALL_STEP in 11 bits; if the sum is at least FALL_END_Y, the block SHALL set text_y=FALL_END_Y and enter HIDE; otherwise it SHALL set text_y to the sum.
REQ-028 In HIDE, text_visible SHALL be 0; dwell SHALL count to HIDE_FRAMES-1, after which the block SHALL set text_y=TEXT_Y0, set text_visible=1, clear dwell, and enter WAIT.
REQ-029 Unreachable state encoding 3 SHALL transition to WAIT with reset values for text_y, text_visible and dwell on the next clock.
REQ-030 Non-advanced frame events SHALL leave frame_cnt, tex_phase, dwell, state, text_y and text_visible unchanged.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set frame_tick=0, frame_cnt=0, tex_phase=0, text_y=TEXT_Y0, text_visible=1, state=WAIT, dwell=0, step_pending=0, vsync_prev=0, and step_prev=1.
REQ-032 vsync held low across reset release SHALL produce no frame event until vsync goes high and then low again.
REQ-033 Reset asserted mid-FALL or mid-HIDE SHALL abort the sequence, and outputs SHALL hold reset values on the edge after assertion.

Verification
REQ-034 The bench SHALL apply reset then 128 vsync falls with defaults, and SHALL check state=FALL, text_y=20, frame_cnt=128.
REQ-035 The bench SHALL continue for 128 more falls, SHALL check state=HIDE, text_y=276, text_visible=0, then after 32 more falls SHALL check state=WAIT, text_y=20, text_visible=1, frame_cnt=288.
REQ-036 The bench SHALL set speed=3 and apply 32 falls, and SHALL check tex_phase steps 0,8,16,... and wraps to 0 at the 32nd frame.
REQ-037 The bench SHALL hold pause=1 for 10 falls, and SHALL check 10 frame_tick pulses with frame_cnt unchanged; it SHALL then pulse step once, and SHALL check frame_cnt+1 at the next fall only.
REQ-038 The bench SHALL preload frame_cnt=0xFFFF via 65535 falls or force, apply one fall, and SHALL check frame_cnt=0.
REQ-039 The bench SHALL assert reset in FALL with text_y=100, and SHALL check all REQ-031 values; it SHALL also hold vsync low through reset release, and SHALL check no frame_tick before the next high-to-low vsync transition.

Source files
------------

// File: rtl/anim_sequencer.sv
// Frame-driven animation sequencer: derives a frame tick from vsync and steps a
// WAIT -> FALL -> HIDE text animation plus a texture scroll phase.
module anim_sequencer #(
  parameter int unsigned TEXT_Y0     = 20,
  parameter int unsigned FALL_END_Y  = 276,
  parameter int unsigned FALL_STEP   = 2,
  parameter int unsigned WAIT_FRAMES = 128,
  parameter int unsigned HIDE_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        pause,
  input  logic        step,
  input  logic [1:0]  speed,
  output logic        frame_tick,
  output logic [15:0] frame_cnt,
  output logic [7:0]  tex_phase,
  output logic [9:0]  text_y,
  output logic        text_visible,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StWait = 2'd0,
    StFall = 2'd1,
    StHide = 2'd2,
    StBad  = 2'd3
  } state_e;

  localparam logic [7:0]  WaitLast = 8'(WAIT_FRAMES - 1);
  localparam logic [7:0]  HideLast = 8'(HIDE_FRAMES - 1);
  localparam logic [9:0]  TextY0   = 10'(TEXT_Y0);
  localparam logic [10:0] FallEnd  = 11'(FALL_END_Y);
  localparam logic [10:0] FallStep = 11'(FALL_STEP);

  state_e      state_q, state_d;
  logic        vsync_prev_q, step_prev_q;
  logic        step_pending_q, step_pending_d;
  logic        frame_tick_q;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  tex_phase_q, tex_phase_d;
  logic [9:0]  text_y_q, text_y_d;
  logic        text_visible_q, text_visible_d;
  logic [7:0]  dwell_q, dwell_d;

  logic        frame_ev, step_edge, advance;
  logic [10:0] fall_sum;

  assign frame_ev  = ~vsync & vsync_prev_q;
  assign step_edge = pause & step & ~step_prev_q;
  assign advance   = frame_ev & (~pause | step_pending_q);
  assign fall_sum  = {1'b0, text_y_q} + FallStep;

  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    tex_phase_d    = tex_phase_q;
    text_y_d       = text_y_q;
    text_visible_d = text_visible_q;
    dwell_d        = dwell_q;
    step_pending_d = step_pending_q;

    // A new edge on the consuming frame re-arms the request for the next frame.
    if (step_edge) begin
      step_pending_d = 1'b1;
    end else if (advance && pause) begin
      step_pending_d = 1'b0;
    end

    if (advance) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      tex_phase_d = tex_phase_q + (8'd1 << speed);
    end

    case (state_q)
      StWait: begin
        if (advance) begin
          if (dwell_q == WaitLast) begin
            state_d = StFall;
            dwell_d = 8'd0;
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
      end
      StFall: begin
        if (advance) begin
          if (fall_sum >= FallEnd) begin
            text_y_d       = FallEnd[9:0];
            text_visible_d = 1'b0;
            state_d        = StHide;
          end else begin
            text_y_d = fall_sum[9:0];
          end
        end
      end
      StHide: begin
        if (advance) begin
          if (dwell_q == HideLast) begin
            text_y_d       = TextY0;
            text_visible_d = 1'b1;
            dwell_d        = 8'd0;
            state_d        = StWait;
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
      end
      default: begin
        state_d        = StWait;
        text_y_d       = TextY0;
        text_visible_d = 1'b1;
        dwell_d        = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StWait;
      vsync_prev_q   <= 1'b0;
      step_prev_q    <= 1'b1;
      step_pending_q <= 1'b0;
      frame_tick_q   <= 1'b0;
      frame_cnt_q    <= 16'd0;
      tex_phase_q    <= 8'd0;
      text_y_q       <= TextY0;
      text_visible_q <= 1'b1;
      dwell_q        <= 8'd0;
    end else begin
      state_q        <= state_d;
      vsync_prev_q   <= vsync;
      step_prev_q    <= step;
      step_pending_q <= step_pending_d;
      frame_tick_q   <= frame_ev;
      frame_cnt_q    <= frame_cnt_d;
      tex_phase_q    <= tex_phase_d;
      text_y_q       <= text_y_d;
      text_visible_q <= text_visible_d;
      dwell_q        <= dwell_d;
    end
  end

  assign frame_tick   = frame_tick_q;
  assign frame_cnt    = frame_cnt_q;
  assign tex_phase    = tex_phase_q;
  assign text_y       = text_y_q;
  assign text_visible = text_visible_q;
  assign state        = state_q;

endmodule
